// File: rtl/matrix_op_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_op_sequencer
//
// Command-driven controller that carries one matrix ALU operation from start
// to finish. For each accepted command it fetches two 256-bit (4x4x16)
// matrices from main memory and loads them into the matrix ALU. It then
// triggers the compute, reads the result back and writes it to main memory.
// The 256-bit data passes through unchanged; no arithmetic is done here.
// Only ADD (opcode 4'h1) is supported. Any other opcode finishes right away
// with an error and produces no bus activity.
//
// Parameters
//   MEM_LAT     main-memory read latency in cycles (>= 1)
//   ALU_BASE    value placed on AluAddr[15:12] to select the matrix ALU
//
// Ports
//   Clk         clock, all logic on the rising edge
//   nReset      synchronous active-low reset
//   CmdValid    command present
//   CmdReady    command can be accepted (IDLE only)
//   CmdOp       operation code
//   CmdSrc1     memory address of the first source matrix
//   CmdSrc2     memory address of the second source matrix
//   CmdDst      memory address for the result matrix
//   CmdDone     one-cycle completion pulse
//   CmdErr      qualifies CmdDone; 1 = unsupported opcode
//   Busy        high in every state except IDLE
//   OpCount     count of successful completions, wraps
//   MemAddr     main-memory address
//   MemnRead    active-low memory read strobe
//   MemnWrite   active-low memory write strobe
//   MemDataIn   memory read data
//   MemDataOut  memory write data
//   AluAddr     matrix ALU address {ALU_BASE, 4'h0, op, sub}
//   AlunRead    active-low ALU read strobe
//   AlunWrite   active-low ALU write strobe
//   AluDataOut  data sent to the ALU
//   AluDataIn   data returned by the ALU
// ---------------------------------------------------------------------------
module matrix_op_sequencer #(
    parameter int         MEM_LAT  = 2,
    parameter logic [3:0] ALU_BASE = 4'h2
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [3:0]   CmdOp,
    input  logic [15:0]  CmdSrc1,
    input  logic [15:0]  CmdSrc2,
    input  logic [15:0]  CmdDst,
    output logic         CmdDone,
    output logic         CmdErr,
    output logic         Busy,
    output logic [15:0]  OpCount,
    output logic [15:0]  MemAddr,
    output logic         MemnRead,
    output logic         MemnWrite,
    input  logic [255:0] MemDataIn,
    output logic [255:0] MemDataOut,
    output logic [15:0]  AluAddr,
    output logic         AlunRead,
    output logic         AlunWrite,
    output logic [255:0] AluDataOut,
    input  logic [255:0] AluDataIn
);

    localparam logic [3:0] OP_ADD = 4'h1;

    // ALU sub-addresses: two operand slots, result port, and compute trigger
    localparam logic [3:0] SUB_SRC1 = 4'h0;
    localparam logic [3:0] SUB_SRC2 = 4'h1;
    localparam logic [3:0] SUB_RES  = 4'h2;
    localparam logic [3:0] SUB_EXEC = 4'h3;

    // The wait counter is loaded with MEM_LAT-1, so it needs one bit when MEM_LAT is 1
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        IDLE,
        ERR,
        MRD1,
        MWT1,
        AWR1,
        MRD2,
        MWT2,
        AWR2,
        EXEC,
        ARD,
        ACAP,
        MWR,
        DONE
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [3:0]       opReg;
    logic [15:0]      src1Reg;
    logic [15:0]      src2Reg;
    logic [15:0]      dstReg;
    logic [255:0]     buffer;
    logic [CNT_W-1:0] waitCnt;

    // State register, command latch, memory wait counter, data buffer and
    // completion counter. A single buffer is enough because each matrix is
    // delivered to its destination before the next one is fetched. The wait
    // counter is armed in MRDx, so the capture happens on the MEM_LAT-th edge
    // after the read strobe.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state   <= IDLE;
            opReg   <= '0;
            src1Reg <= '0;
            src2Reg <= '0;
            dstReg  <= '0;
            buffer  <= '0;
            waitCnt <= '0;
            OpCount <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && CmdValid) begin
                opReg   <= CmdOp;
                src1Reg <= CmdSrc1;
                src2Reg <= CmdSrc2;
                dstReg  <= CmdDst;
            end
            if (state == MRD1 || state == MRD2) begin
                waitCnt <= LAT_M1;
            end else if ((state == MWT1 || state == MWT2) && waitCnt != '0) begin
                waitCnt <= waitCnt - 1'b1;
            end
            if ((state == MWT1 || state == MWT2) && waitCnt == '0) begin
                buffer <= MemDataIn;
            end else if (state == ACAP) begin
                buffer <= AluDataIn;
            end
            if (state == DONE) begin
                OpCount <= OpCount + 16'd1;
            end
        end
    end

    // Next-state and bus decode. Every output falls back to its idle value:
    // strobes high and addresses and data at zero. The ALU ignores an idle
    // bus because AluAddr[15:12] does not match ALU_BASE. Each state drives
    // at most one bus and at most one strobe, so the memory and ALU buses
    // are never active in the same cycle.
    always_comb begin
        nextState  = state;
        CmdReady   = 1'b0;
        CmdDone    = 1'b0;
        CmdErr     = 1'b0;
        Busy       = 1'b1;
        MemAddr    = '0;
        MemnRead   = 1'b1;
        MemnWrite  = 1'b1;
        MemDataOut = '0;
        AluAddr    = '0;
        AlunRead   = 1'b1;
        AlunWrite  = 1'b1;
        AluDataOut = '0;

        unique case (state)
            IDLE: begin
                Busy     = 1'b0;
                CmdReady = 1'b1;
                if (CmdValid) begin
                    nextState = (CmdOp == OP_ADD) ? MRD1 : ERR;
                end
            end
            ERR: begin
                CmdDone   = 1'b1;
                CmdErr    = 1'b1;
                nextState = IDLE;
            end
            MRD1: begin
                MemAddr   = src1Reg;
                MemnRead  = 1'b0;
                nextState = MWT1;
            end
            MWT1: begin
                if (waitCnt == '0) begin
                    nextState = AWR1;
                end
            end
            AWR1: begin
                AluAddr    = {ALU_BASE, 4'h0, opReg, SUB_SRC1};
                AlunWrite  = 1'b0;
                AluDataOut = buffer;
                nextState  = MRD2;
            end
            MRD2: begin
                MemAddr   = src2Reg;
                MemnRead  = 1'b0;
                nextState = MWT2;
            end
            MWT2: begin
                if (waitCnt == '0) begin
                    nextState = AWR2;
                end
            end
            AWR2: begin
                AluAddr    = {ALU_BASE, 4'h0, opReg, SUB_SRC2};
                AlunWrite  = 1'b0;
                AluDataOut = buffer;
                nextState  = EXEC;
            end
            EXEC: begin
                AluAddr   = {ALU_BASE, 4'h0, opReg, SUB_EXEC};
                nextState = ARD;
            end
            ARD: begin
                AluAddr   = {ALU_BASE, 4'h0, opReg, SUB_RES};
                AlunRead  = 1'b0;
                nextState = ACAP;
            end
            ACAP: begin
                AluAddr   = {ALU_BASE, 4'h0, opReg, SUB_RES};
                nextState = MWR;
            end
            MWR: begin
                MemAddr    = dstReg;
                MemnWrite  = 1'b0;
                MemDataOut = buffer;
                nextState  = DONE;
            end
            DONE: begin
                CmdDone   = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_op_sequencer
//
// Testbench for matrix_op_sequencer. It models main memory with a fixed read
// latency and a matrix ALU that adds lane by lane. It issues directed
// commands, each carrying a hand-computed expected result. A negedge monitor
// pops a scoreboard entry on every CmdDone and compares the error flag, the
// latency, the destination contents and the following OpCount. On every
// cycle it also checks that the strobes are never active on both buses at once.
// ---------------------------------------------------------------------------
module tb_matrix_op_sequencer;

    localparam int         MEM_LAT  = 2;
    localparam logic [3:0] ALU_BASE = 4'h2;
    localparam int         ADD_LAT  = 2 * MEM_LAT + 9;

    logic         Clk = 1'b0;
    logic         nReset;
    logic         CmdValid;
    logic         CmdReady;
    logic [3:0]   CmdOp;
    logic [15:0]  CmdSrc1;
    logic [15:0]  CmdSrc2;
    logic [15:0]  CmdDst;
    logic         CmdDone;
    logic         CmdErr;
    logic         Busy;
    logic [15:0]  OpCount;
    logic [15:0]  MemAddr;
    logic         MemnRead;
    logic         MemnWrite;
    logic [255:0] MemDataIn = '0;
    logic [255:0] MemDataOut;
    logic [15:0]  AluAddr;
    logic         AlunRead;
    logic         AlunWrite;
    logic [255:0] AluDataOut;
    logic [255:0] AluDataIn = '0;

    matrix_op_sequencer #(
        .MEM_LAT (MEM_LAT),
        .ALU_BASE(ALU_BASE)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdOp     (CmdOp),
        .CmdSrc1   (CmdSrc1),
        .CmdSrc2   (CmdSrc2),
        .CmdDst    (CmdDst),
        .CmdDone   (CmdDone),
        .CmdErr    (CmdErr),
        .Busy      (Busy),
        .OpCount   (OpCount),
        .MemAddr   (MemAddr),
        .MemnRead  (MemnRead),
        .MemnWrite (MemnWrite),
        .MemDataIn (MemDataIn),
        .MemDataOut(MemDataOut),
        .AluAddr   (AluAddr),
        .AlunRead  (AlunRead),
        .AlunWrite (AlunWrite),
        .AluDataOut(AluDataOut),
        .AluDataIn (AluDataIn)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic         err;
        int           lat;
        logic [15:0]  dst;
        logic [255:0] data;
        logic [15:0]  cnt;
    } exp_t;

    exp_t         sbQueue[$];
    logic [255:0] mem[logic [15:0]];

    int           assertions = 0;
    int           failures = 0;
    int           cyc = 0;
    int           acceptCyc = 0;
    int           acceptCount = 0;
    int           lastAcceptCyc = 0;
    int           lastDoneCyc = 0;
    int           doneCount = 0;
    int           strobeLowCount = 0;
    int           memReadCount = 0;
    logic         countCheckPending = 1'b0;
    logic [15:0]  pendingCnt = '0;
    logic [15:0]  expCount = '0;

    function automatic logic [255:0] memRead(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic err, input int lat, input logic [15:0] dst,
                                input logic [255:0] data, input logic [15:0] cnt);
        exp_t e;
        e.err  = err;
        e.lat  = lat;
        e.dst  = dst;
        e.data = data;
        e.cnt  = cnt;
        sbQueue.push_back(e);
    endtask

    // Main memory: writes land on the edge ending MWR. A read sampled on edge E
    // puts junk on the bus until edge E+MEM_LAT-1, where the real data appears,
    // so it is stable for the capture on edge E+MEM_LAT.
    int          rdCnt = 0;
    logic [15:0] rdAddr = '0;
    always @(posedge Clk) begin
        if (MemnWrite === 1'b0) mem[MemAddr] = MemDataOut;
        if (MemnRead === 1'b0) begin
            rdAddr = MemAddr;
            rdCnt  = MEM_LAT;
        end
        if (rdCnt > 0) begin
            rdCnt--;
            MemDataIn <= (rdCnt == 0) ? memRead(rdAddr) : {8{32'hDEADBEEF}};
        end
    end

    // Matrix ALU: two operand slots, a compute trigger and a registered result port
    logic [255:0] aluA = '0;
    logic [255:0] aluB = '0;
    logic [255:0] aluR = '0;
    always @(posedge Clk) begin
        if (AluAddr[15:12] == ALU_BASE) begin
            case (AluAddr[3:0])
                4'h0: if (!AlunWrite) aluA <= AluDataOut;
                4'h1: if (!AlunWrite) aluB <= AluDataOut;
                4'h2: if (!AlunRead) AluDataIn <= aluR;
                4'h3: if (AlunRead && AlunWrite && AluAddr[7:4] == 4'h1) begin
                    for (int i = 0; i < 16; i++) begin
                        aluR[16*i +: 16] <= aluA[16*i +: 16] + aluB[16*i +: 16];
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge Clk) cyc++;

    // Monitor: checks the strobe rules, accounts for accepts, and compares each completion against the scoreboard
    always @(negedge Clk) begin
        logic memAct;
        logic aluAct;
        exp_t e;
        memAct = !MemnRead || !MemnWrite;
        aluAct = !AlunRead || !AlunWrite;
        checkOutput("strobeRules",
                    {255'd0, (!MemnRead && !MemnWrite) || (!AlunRead && !AlunWrite) || (memAct && aluAct)},
                    256'd0);
        if (memAct || aluAct) strobeLowCount++;
        if (!MemnRead) memReadCount++;
        if (countCheckPending) begin
            checkOutput("opCount", {240'd0, OpCount}, {240'd0, pendingCnt});
            countCheckPending = 1'b0;
        end
        if (CmdDone) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedDone", 256'd1, 256'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("cmdErr", {255'd0, CmdErr}, {255'd0, e.err});
                checkOutput("latency", 256'(cyc - acceptCyc), 256'(e.lat));
                if (!e.err) checkOutput("dstData", memRead(e.dst), e.data);
                countCheckPending = 1'b1;
                pendingCnt = e.cnt;
            end
            doneCount++;
            lastDoneCyc = cyc;
        end
        if (nReset && CmdValid && CmdReady) begin
            acceptCyc = cyc;
            lastAcceptCyc = cyc;
            acceptCount++;
        end
    end

    // Drive one command and hold it until the DUT takes it
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] s1,
                                 input logic [15:0] s2, input logic [15:0] d);
        int start;
        start = acceptCount;
        @(posedge Clk);
        #1;
        CmdOp    = op;
        CmdSrc1  = s1;
        CmdSrc2  = s2;
        CmdDst   = d;
        CmdValid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge Clk);
            #1;
            if (acceptCount != start) break;
        end
        CmdValid = 1'b0;
        if (acceptCount == start) checkOutput("acceptTimeout", 256'd1, 256'd0);
    endtask

    task automatic waitDone(input int target);
        for (int i = 0; i < 200; i++) begin
            if (doneCount >= target) break;
            @(posedge Clk);
        end
        #1;
        if (doneCount < target) checkOutput("doneTimeout", 256'd1, 256'd0);
        @(negedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int snap;
        int startAcc;
        int startDone;

        mem[16'h0100] = {16{16'd3}};
        mem[16'h0200] = {16{16'd5}};
        mem[16'h0600] = {16{16'h1234}};
        mem[16'h0700] = {16{16'h0101}};

        // T1: reset held for two cycles with a command pending
        nReset   = 1'b0;
        CmdValid = 1'b1;
        CmdOp    = 4'h1;
        CmdSrc1  = 16'h0100;
        CmdSrc2  = 16'h0200;
        CmdDst   = 16'h0300;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rstStrobes", {252'd0, MemnRead, MemnWrite, AlunRead, AlunWrite}, 256'hF);
        checkOutput("rstBusyDone", {253'd0, Busy, CmdDone, CmdErr}, 256'd0);
        checkOutput("rstAddr", {224'd0, MemAddr, AluAddr}, 256'd0);
        checkOutput("rstData", MemDataOut | AluDataOut, 256'd0);
        nReset   = 1'b1;
        CmdValid = 1'b0;
        @(negedge Clk);
        checkOutput("rstReady", {255'd0, CmdReady}, 256'd1);
        checkOutput("rstOpCount", {240'd0, OpCount}, 256'd0);
        checkOutput("rstNoAccept", 256'(acceptCount), 256'd0);

        // T2: ADD 3 + 5 -> 8 in every lane
        expCount = 16'd1;
        pushExpected(1'b0, ADD_LAT, 16'h0300, {16{16'd8}}, expCount);
        applyStimulus(4'h1, 16'h0100, 16'h0200, 16'h0300);
        waitDone(1);

        // T3: unsupported opcode, no bus activity and count unchanged
        snap = strobeLowCount;
        pushExpected(1'b1, 1, 16'h0000, '0, expCount);
        applyStimulus(4'h3, 16'h0100, 16'h0200, 16'h0310);
        waitDone(2);
        checkOutput("errNoStrobes", 256'(strobeLowCount - snap), 256'd0);
        checkOutput("errNoWrite", {255'd0, mem.exists(16'h0310)}, 256'd0);

        // T4: reset during MWT2 aborts the command before it writes to Dst
        snap = memReadCount;
        pushExpected(1'b0, ADD_LAT, 16'h0400, {16{16'd8}}, 16'd2);
        applyStimulus(4'h1, 16'h0100, 16'h0200, 16'h0400);
        repeat (MEM_LAT + 3) @(posedge Clk);
        #1;
        checkOutput("midOpReads", 256'(memReadCount - snap), 256'd2);
        nReset = 1'b0;
        sbQueue.delete();
        expCount = 16'd0;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        checkOutput("midOpIdle", {254'd0, Busy, CmdReady}, 256'd1);
        checkOutput("midOpCount", {240'd0, OpCount}, 256'd0);
        repeat (20) @(posedge Clk);
        #1;
        checkOutput("midOpNoWrite", {255'd0, mem.exists(16'h0400)}, 256'd0);
        startDone = doneCount;
        expCount = 16'd1;
        pushExpected(1'b0, ADD_LAT, 16'h0500, {16{16'd8}}, expCount);
        applyStimulus(4'h1, 16'h0100, 16'h0200, 16'h0500);
        waitDone(startDone + 1);

        // T5: two ADDs with CmdValid held high throughout
        startAcc  = acceptCount;
        startDone = doneCount;
        pushExpected(1'b0, ADD_LAT, 16'h0800, {16{16'h1335}}, 16'd2);
        pushExpected(1'b0, ADD_LAT, 16'h0900, {16{16'h1237}}, 16'd3);
        @(posedge Clk);
        #1;
        CmdOp    = 4'h1;
        CmdSrc1  = 16'h0600;
        CmdSrc2  = 16'h0700;
        CmdDst   = 16'h0800;
        CmdValid = 1'b1;
        for (int i = 0; i < 50 && acceptCount == startAcc; i++) begin
            @(posedge Clk);
            #1;
        end
        CmdSrc1 = 16'h0100;
        CmdSrc2 = 16'h0600;
        CmdDst  = 16'h0900;
        for (int i = 0; i < 100 && acceptCount < startAcc + 2; i++) begin
            @(posedge Clk);
            #1;
        end
        CmdValid = 1'b0;
        checkOutput("b2bAccepts", 256'(acceptCount - startAcc), 256'd2);
        checkOutput("b2bGap", 256'(lastAcceptCyc - lastDoneCyc), 256'd1);
        waitDone(startDone + 2);

        // T6: counter wraps from 16'hFFFF to zero
        @(posedge Clk);
        #1;
        force dut.OpCount = 16'hFFFF;
        @(posedge Clk);
        #1;
        release dut.OpCount;
        @(posedge Clk);
        #1;
        checkOutput("wrapPreload", {240'd0, OpCount}, {240'd0, 16'hFFFF});
        startDone = doneCount;
        pushExpected(1'b0, ADD_LAT, 16'h0A00, {16{16'd8}}, 16'd0);
        applyStimulus(4'h1, 16'h0100, 16'h0200, 16'h0A00);
        waitDone(startDone + 1);

        repeat (3) @(posedge Clk);
        #1;
        checkOutput("sbEmpty", 256'(sbQueue.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
